// File: rtl/alu_mul_seq.sv
// Shift-and-add 8x8->16 multiply sequencer that borrows the shared ALU (kADD/kSRL).
// Optional MUL_ZERO_SKIP_EN: zero operands finish in one cycle without touching the ALU.
package alu_defs_pkg;
  localparam logic [4:0] kMOV = 5'd0;
  localparam logic [4:0] kADD = 5'd1;
  localparam logic [4:0] kSRL = 5'd7;
endpackage

module alu_mul_seq
  import alu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [4:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_rslt,
  input  logic             alu_co
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = mcand;
          hi_d    = '0;
          lo_d    = mplier;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = mplier[0] ? S_ADD : S_SHIFT;
`ifdef MUL_ZERO_SKIP_EN
          if (mcand == '0 || mplier == '0) begin
            lo_d    = '0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_ADD: begin
        hi_d    = alu_rslt;
        carry_d = alu_co;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // ALU shifts hi right by one; the saved add carry becomes the new MSB.
        hi_d    = {carry_q, alu_rslt[WIDTH-2:0]};
        lo_d    = {hi_q[0], lo_q[WIDTH-1:1]};
        carry_d = 1'b0;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = lo_q[1] ? S_ADD : S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    busy    = (state_q == S_ADD) || (state_q == S_SHIFT);
    done    = (state_q == S_DONE);
    prod_hi = hi_q;
    prod_lo = lo_q;
    alu_op  = kMOV;
    alu_a   = '0;
    alu_b   = '0;
    unique case (state_q)
      S_ADD: begin
        alu_op = kADD;
        alu_a  = hi_q;
        alu_b  = mcand_q;
      end
      S_SHIFT: begin
        alu_op = kSRL;
        alu_a  = hi_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: behavioural ALU, directed cases, random sweep vs a*b.
module tb_alu_mul_seq;
  import alu_defs_pkg::*;

  localparam int WINDOW = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mcand, mplier;
  logic       busy, done;
  logic [7:0] prod_hi, prod_lo;
  logic [4:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_rslt;
  logic       alu_co;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_rslt(alu_rslt), .alu_co(alu_co)
  );

  // Shared ALU: add with carry-out, single-bit logical right shift, move of in_b.
  always_comb begin
    alu_rslt = alu_b;
    alu_co   = 1'b0;
    case (alu_op)
      kADD:    {alu_co, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b};
      kSRL:    alu_rslt = alu_a >> 1;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_ZERO_SKIP_EN
    if (a == 8'd0 || b == 8'd0) return 1;
`endif
    return 9 + $countones(b);
  endfunction

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input string tag);
    int lat, ndone, nbusy, nbadop, nadd, exp_lat;
    logic [15:0] prod_at_done, exp_prod;
    exp_prod = 16'(int'(a) * int'(b));
    exp_lat  = ref_latency(a, b);
    start = 1'b1; mcand = a; mplier = b;
    tick();
    start = 1'b0; mcand = 8'($urandom); mplier = 8'($urandom);
    lat = 0; ndone = 0; nbusy = 0; nbadop = 0; nadd = 0; prod_at_done = '0;
    for (int c = 1; c <= WINDOW; c++) begin
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = c;
          prod_at_done = {prod_hi, prod_lo};
        end
      end
      if (alu_op === kADD) nadd++;
      if (busy) begin
        nbusy++;
        if (alu_op !== kADD && alu_op !== kSRL) nbadop++;
      end else if (alu_op !== kMOV) begin
        nbadop++;
      end
      tick();
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " busy_cycles"}, nbusy, exp_lat - 1);
    chk({tag, " alu_op_legal"}, nbadop, 0);
    chk({tag, " product"}, prod_at_done, exp_prod);
    chk({tag, " product_held"}, {prod_hi, prod_lo}, exp_prod);
    if (b == 8'd0) chk({tag, " no_kADD"}, nadd, 0);
  endtask

  initial begin
    int lat, ndone;
    reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    repeat (2) tick();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset prod", {prod_hi, prod_lo}, 0);
    chk("reset alu_op", alu_op, kMOV);
    chk("reset alu_ab", {alu_a, alu_b}, 0);
    reset = 1'b0;
    tick();

    run_mul(8'd13, 8'd11, "13x11");
    run_mul(8'hFF, 8'hFF, "FFxFF");
    run_mul(8'h5A, 8'h00, "5Ax00");
    run_mul(8'h00, 8'h37, "00x37");

    // Re-pulsed start while busy must be ignored.
    start = 1'b1; mcand = 8'd3; mplier = 8'h81;
    tick();
    start = 1'b0;
    lat = 0; ndone = 0;
    for (int c = 1; c <= WINDOW; c++) begin
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = c;
          chk("repulse product", {prod_hi, prod_lo}, 16'h0183);
        end
      end
      if (c == 2 || c == 9) begin start = 1'b1; mcand = 8'd7; mplier = 8'h01; end
      if (c == 3 || c == 10) start = 1'b0;
      tick();
    end
    chk("repulse latency", lat, 11);
    chk("repulse done_count", ndone, 1);
    chk("repulse product_held", {prod_hi, prod_lo}, 16'h0183);

    // Asynchronous reset mid-operation.
    start = 1'b1; mcand = 8'd200; mplier = 8'd200;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset prod", {prod_hi, prod_lo}, 0);
    chk("midreset alu_op", alu_op, kMOV);
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < WINDOW; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("midreset no_done", ndone, 0);
    run_mul(8'd200, 8'd200, "200x200");

    for (int i = 0; i < 1000; i++) begin
      run_mul(8'($urandom), 8'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
